// File: rtl/ddr_rd_data_checker.sv
// ddr_rd_data_checker: 3-stage PRBS read-beat compare with pattern-lock FSM and saturating stats.
// Optional first-error capture is built when FIRST_ERR_CAPTURE_EN is defined.
module ddr_rd_data_checker #(
   parameter int unsigned DATA_W   = 128,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned LOCK_CNT = 16,
   parameter int unsigned LOSS_CNT = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              chk_en,
   input  logic              clr,
   input  logic              rd_valid,
   input  logic [DATA_W-1:0] rd_data,
   input  logic [DATA_W-1:0] exp_data,
   output logic              exp_adv,
   output logic              lock,
   output logic              err_flag,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic [CNT_W-1:0]  err_beat_cnt,
   output logic [CNT_W-1:0]  err_bit_cnt,
   output logic [DATA_W-1:0] first_err_xor,
   output logic [CNT_W-1:0]  first_err_idx
);
   localparam int unsigned PC_W  = $clog2(DATA_W + 1);
   localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam int unsigned GR_W  = $clog2(LOCK_CNT + 1);
   localparam int unsigned BR_W  = $clog2(LOSS_CNT + 1);
   localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'({CNT_W{1'b1}});

   typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_e;

   state_e            state_q, state_d;
   logic              v1_q, v2_q, mis2_q;
   logic [DATA_W-1:0] x1_q;
   logic [PC_W-1:0]   pc2_q;
   logic [GR_W-1:0]   good_q, good_d;
   logic [BR_W-1:0]   bad_q, bad_d;
   logic [CNT_W-1:0]  beat_q, beat_d, ebeat_q, ebeat_d, ebit_q, ebit_d;
   logic              flag_q, flag_d;
   logic [SUM_W-1:0]  bit_sum;

   function automatic logic [PC_W-1:0] popcount(input logic [DATA_W-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < DATA_W; i++) n = n + PC_W'(v[i]);
      return n;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign exp_adv = rd_valid & chk_en;
   assign bit_sum = SUM_W'(ebit_q) + SUM_W'(pc2_q);

   // Gating v2 with chk_en discards a beat already in S1 when the checker is disabled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1_q   <= 1'b0;
         x1_q   <= '0;
         v2_q   <= 1'b0;
         mis2_q <= 1'b0;
         pc2_q  <= '0;
      end else begin
         v1_q   <= rd_valid & chk_en;
         x1_q   <= rd_data ^ exp_data;
         v2_q   <= v1_q & chk_en;
         mis2_q <= |x1_q;
         pc2_q  <= popcount(x1_q);
      end
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      bad_d   = bad_q;
      beat_d  = beat_q;
      ebeat_d = ebeat_q;
      ebit_d  = ebit_q;
      flag_d  = flag_q;
      if (!chk_en) begin
         state_d = IDLE;
         good_d  = '0;
         bad_d   = '0;
      end else begin
         unique case (state_q)
            IDLE:   state_d = SEARCH;
            SEARCH: if (v2_q) begin
               if (mis2_q) good_d = '0;
               else if (good_q == GR_W'(LOCK_CNT - 1)) begin
                  state_d = LOCKED;
                  good_d  = '0;
                  bad_d   = '0;
               end else good_d = good_q + GR_W'(1);
            end
            LOCKED: if (v2_q) begin
               beat_d = sat_inc(beat_q);
               if (mis2_q) begin
                  ebeat_d = sat_inc(ebeat_q);
                  ebit_d  = (bit_sum > SUM_MAX) ? '1 : CNT_W'(bit_sum);
                  flag_d  = 1'b1;
                  if (bad_q == BR_W'(LOSS_CNT - 1)) begin
                     state_d = SEARCH;
                     bad_d   = '0;
                     good_d  = '0;
                  end else bad_d = bad_q + BR_W'(1);
               end else bad_d = '0;
            end
            default: state_d = IDLE;
         endcase
      end
      // clr overrides any statistic update from the beat in S3; run counters keep tracking.
      if (clr) begin
         beat_d  = '0;
         ebeat_d = '0;
         ebit_d  = '0;
         flag_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         good_q  <= '0;
         bad_q   <= '0;
         beat_q  <= '0;
         ebeat_q <= '0;
         ebit_q  <= '0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         beat_q  <= beat_d;
         ebeat_q <= ebeat_d;
         ebit_q  <= ebit_d;
         flag_q  <= flag_d;
      end
   end

   assign lock         = (state_q == LOCKED);
   assign err_flag     = flag_q;
   assign beat_cnt     = beat_q;
   assign err_beat_cnt = ebeat_q;
   assign err_bit_cnt  = ebit_q;

`ifdef FIRST_ERR_CAPTURE_EN
   logic [DATA_W-1:0] x2_q, fx_q, fx_d;
   logic [CNT_W-1:0]  fidx_q, fidx_d;
   logic              count_err;

   assign count_err = chk_en && (state_q == LOCKED) && v2_q && mis2_q;

   // An errored beat always has a non-zero xor, so a zero capture register means "armed".
   always_comb begin
      fx_d   = fx_q;
      fidx_d = fidx_q;
      if (clr) begin
         fx_d   = '0;
         fidx_d = '0;
      end else if (count_err && (fx_q == '0)) begin
         fx_d   = x2_q;
         fidx_d = beat_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         x2_q   <= '0;
         fx_q   <= '0;
         fidx_q <= '0;
      end else begin
         x2_q   <= x1_q;
         fx_q   <= fx_d;
         fidx_q <= fidx_d;
      end
   end

   assign first_err_xor = fx_q;
   assign first_err_idx = fidx_q;
`else
   assign first_err_xor = '0;
   assign first_err_idx = '0;
`endif

endmodule

// File: tb/tb_ddr_rd_data_checker.sv
// Self-checking bench for ddr_rd_data_checker: 32-bit and 4-bit counter instances share stimulus
// and are compared against a per-beat behavioural model of lock and statistics.
module tb_ddr_rd_data_checker;
   logic         clk = 1'b0;
   logic         rstn, chk_en, clr, rd_valid;
   logic [127:0] rd_data, exp_data;

   logic         exp_adv, lock, err_flag;
   logic [31:0]  beat_cnt, err_beat_cnt, err_bit_cnt, first_err_idx;
   logic [127:0] first_err_xor;

   logic         exp_adv4, lock4, err_flag4;
   logic [3:0]   beat_cnt4, err_beat_cnt4, err_bit_cnt4, first_err_idx4;
   logic [127:0] first_err_xor4;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: unbounded counts, saturation applied when comparing.
   bit           m_en, m_locked, m_flag, m_cap;
   int           m_good, m_bad;
   longint       m_beats, m_ebeats, m_ebits, m_fidx;
   logic [127:0] m_fx;

   ddr_rd_data_checker #(.DATA_W(128), .CNT_W(32), .LOCK_CNT(16), .LOSS_CNT(4)) u_dut (
      .clk(clk), .rstn(rstn), .chk_en(chk_en), .clr(clr), .rd_valid(rd_valid),
      .rd_data(rd_data), .exp_data(exp_data), .exp_adv(exp_adv), .lock(lock),
      .err_flag(err_flag), .beat_cnt(beat_cnt), .err_beat_cnt(err_beat_cnt),
      .err_bit_cnt(err_bit_cnt), .first_err_xor(first_err_xor), .first_err_idx(first_err_idx)
   );

   ddr_rd_data_checker #(.DATA_W(128), .CNT_W(4), .LOCK_CNT(16), .LOSS_CNT(4)) u_dut4 (
      .clk(clk), .rstn(rstn), .chk_en(chk_en), .clr(clr), .rd_valid(rd_valid),
      .rd_data(rd_data), .exp_data(exp_data), .exp_adv(exp_adv4), .lock(lock4),
      .err_flag(err_flag4), .beat_cnt(beat_cnt4), .err_beat_cnt(err_beat_cnt4),
      .err_bit_cnt(err_bit_cnt4), .first_err_xor(first_err_xor4), .first_err_idx(first_err_idx4)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic longint sat(input longint v, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic m_reset();
      m_locked = 0; m_good = 0; m_bad = 0;
      m_beats = 0; m_ebeats = 0; m_ebits = 0; m_flag = 0;
      m_cap = 0; m_fx = '0; m_fidx = 0;
   endtask

   task automatic m_clear();
      m_beats = 0; m_ebeats = 0; m_ebits = 0; m_flag = 0;
      m_cap = 0; m_fx = '0; m_fidx = 0;
   endtask

   task automatic m_disable();
      m_en = 0; m_locked = 0; m_good = 0; m_bad = 0;
   endtask

   // One consumed beat with mismatch pattern x; stats=0 means a coincident clr suppressed counting.
   task automatic m_beat(input logic [127:0] x, input bit stats);
      bit bad;
      bad = (x != '0);
      if (!m_en) return;
      if (!m_locked) begin
         if (bad) m_good = 0;
         else begin
            m_good++;
            if (m_good == 16) begin m_locked = 1; m_good = 0; m_bad = 0; end
         end
      end else begin
         if (stats) begin
            if (bad) begin
               if (!m_cap) begin m_cap = 1; m_fx = x; m_fidx = m_beats; end
               m_ebeats++;
               m_ebits += $countones(x);
               m_flag = 1;
            end
            m_beats++;
         end
         if (bad) begin
            m_bad++;
            if (m_bad == 4) begin m_locked = 0; m_bad = 0; m_good = 0; end
         end else m_bad = 0;
      end
   endtask

   // Present one beat for a single cycle; returns 1ns after the capturing edge.
   task automatic beat(input logic [127:0] x, input bit apply);
      exp_data = rand128();
      rd_data  = exp_data ^ x;
      rd_valid = 1'b1;
      if (apply) m_beat(x, 1);
      @(negedge clk);
      n_vec++;
      if (exp_adv !== m_en) begin
         n_err++; $display("FAIL exp_adv: got %b expected %b", exp_adv, m_en);
      end
      n_vec++;
      if (exp_adv4 !== m_en) begin
         n_err++; $display("FAIL exp_adv4: got %b expected %b", exp_adv4, m_en);
      end
      @(posedge clk); #1;
      rd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      rd_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      m_clear();
      @(posedge clk); #1;
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; chk_en = 1'b0; clr = 1'b0; rd_valid = 1'b0;
      rd_data = '0; exp_data = '0;
      m_en = 0; m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({lock, err_flag, beat_cnt, err_beat_cnt, err_bit_cnt} !== '0) begin
         n_err++; $display("FAIL reset_state: got lock=%b flag=%b beats=%0d ebeats=%0d ebits=%0d expected all 0",
                           lock, err_flag, beat_cnt, err_beat_cnt, err_bit_cnt);
      end
      n_vec++;
      if ({lock4, err_flag4, beat_cnt4, err_beat_cnt4, err_bit_cnt4} !== '0) begin
         n_err++; $display("FAIL reset_state4: got lock=%b flag=%b beats=%0d expected all 0",
                           lock4, err_flag4, beat_cnt4);
      end
      n_vec++;
      if (first_err_xor !== '0 || first_err_idx !== '0) begin
         n_err++; $display("FAIL reset_capture: got xor=%h idx=%0d expected 0", first_err_xor, first_err_idx);
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      idle(1);
      for (int i = 0; i < 10; i++) beat(($urandom_range(0, 1) == 0) ? '0 : rand128(), 1);
      idle(4);
      n_vec++;
      if (lock !== 1'b0 || beat_cnt !== 32'd0 || err_beat_cnt !== 32'd0 || err_bit_cnt !== 32'd0) begin
         n_err++; $display("FAIL disabled_beats: got lock=%b beats=%0d ebeats=%0d ebits=%0d expected 0",
                           lock, beat_cnt, err_beat_cnt, err_bit_cnt);
      end
   endtask

   task automatic test_lock();
      chk_en = 1'b1; m_en = 1;
      for (int i = 0; i < 16; i++) beat('0, 1);
      rd_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (lock !== 1'b0) begin n_err++; $display("FAIL lock_lat1: got %b expected 0", lock); end
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (lock !== 1'b0) begin n_err++; $display("FAIL lock_lat2: got %b expected 0", lock); end
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (lock !== m_locked) begin n_err++; $display("FAIL lock_lat3: got %b expected %b", lock, m_locked); end
      n_vec++;
      if (beat_cnt !== 32'd0 || err_beat_cnt !== 32'd0 || err_bit_cnt !== 32'd0) begin
         n_err++; $display("FAIL lock_counts: got beats=%0d ebeats=%0d ebits=%0d expected 0",
                           beat_cnt, err_beat_cnt, err_bit_cnt);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_bit_err();
      beat(128'h1, 1);
      idle(4);
      n_vec++;
      if (err_beat_cnt !== 32'(m_ebeats) || err_bit_cnt !== 32'(m_ebits)) begin
         n_err++; $display("FAIL single_bit_cnts: got ebeats=%0d ebits=%0d expected %0d %0d",
                           err_beat_cnt, err_bit_cnt, m_ebeats, m_ebits);
      end
      n_vec++;
      if (err_flag !== 1'b1 || lock !== m_locked) begin
         n_err++; $display("FAIL single_bit_flag: got flag=%b lock=%b expected 1 %b", err_flag, lock, m_locked);
      end
      n_vec++;
      if (beat_cnt !== 32'(m_beats)) begin
         n_err++; $display("FAIL single_bit_beats: got %0d expected %0d", beat_cnt, m_beats);
      end
`ifdef FIRST_ERR_CAPTURE_EN
      n_vec++;
      if (first_err_xor !== m_fx || first_err_idx !== 32'(m_fidx)) begin
         n_err++; $display("FAIL first_capture: got xor=%h idx=%0d expected %h %0d",
                           first_err_xor, first_err_idx, m_fx, m_fidx);
      end
`else
      n_vec++;
      if (first_err_xor !== '0 || first_err_idx !== '0) begin
         n_err++; $display("FAIL capture_tied: got xor=%h idx=%0d expected 0", first_err_xor, first_err_idx);
      end
`endif
   endtask

   task automatic test_multi_bit();
      logic [127:0] ones;
      ones = '1;
      beat('0, 1);
      idle(1);
      pulse_clr();
      beat(ones, 1);
      beat(128'hFF, 1);
      idle(4);
      n_vec++;
      if (err_bit_cnt !== 32'd136 || err_bit_cnt !== 32'(m_ebits)) begin
         n_err++; $display("FAIL multi_bit_bits: got %0d expected 136 (model %0d)", err_bit_cnt, m_ebits);
      end
      n_vec++;
      if (err_beat_cnt !== 32'(m_ebeats) || lock !== m_locked) begin
         n_err++; $display("FAIL multi_bit_beats: got ebeats=%0d lock=%b expected %0d %b",
                           err_beat_cnt, lock, m_ebeats, m_locked);
      end
      n_vec++;
      if (err_bit_cnt4 !== 4'(sat(m_ebits, 4))) begin
         n_err++; $display("FAIL multi_bit_sat4: got %0d expected %0d", err_bit_cnt4, sat(m_ebits, 4));
      end
`ifdef FIRST_ERR_CAPTURE_EN
      n_vec++;
      if (first_err_xor !== ones || first_err_idx !== 32'(m_fidx)) begin
         n_err++; $display("FAIL recapture: got xor=%h idx=%0d expected %h %0d",
                           first_err_xor, first_err_idx, ones, m_fidx);
      end
`endif
   endtask

   task automatic test_loss_relock();
      logic [127:0] x;
      beat('0, 1);
      for (int i = 0; i < 4; i++) begin
         x = '0;
         x[$urandom_range(0, 127)] = 1'b1;
         beat(x, 1);
      end
      idle(4);
      n_vec++;
      if (lock !== 1'b0 || lock !== m_locked) begin
         n_err++; $display("FAIL loss_lock: got %b expected 0", lock);
      end
      n_vec++;
      if (err_beat_cnt !== 32'(m_ebeats) || beat_cnt !== 32'(m_beats)) begin
         n_err++; $display("FAIL loss_counts: got ebeats=%0d beats=%0d expected %0d %0d",
                           err_beat_cnt, beat_cnt, m_ebeats, m_beats);
      end
      for (int i = 0; i < 16; i++) beat('0, 1);
      idle(4);
      n_vec++;
      if (lock !== 1'b1 || lock !== m_locked) begin
         n_err++; $display("FAIL relock: got %b expected 1", lock);
      end
   endtask

   task automatic test_chk_en_drop();
      beat(128'hF0, 0);
      chk_en = 1'b0;
      m_disable();
      idle(4);
      n_vec++;
      if (lock !== 1'b0 || err_beat_cnt !== 32'(m_ebeats) || err_bit_cnt !== 32'(m_ebits)) begin
         n_err++; $display("FAIL chk_en_drop: got lock=%b ebeats=%0d ebits=%0d expected 0 %0d %0d",
                           lock, err_beat_cnt, err_bit_cnt, m_ebeats, m_ebits);
      end
      chk_en = 1'b1; m_en = 1;
      for (int i = 0; i < 16; i++) beat('0, 1);
      idle(4);
      n_vec++;
      if (lock !== m_locked || beat_cnt !== 32'(m_beats)) begin
         n_err++; $display("FAIL chk_en_relock: got lock=%b beats=%0d expected %b %0d",
                           lock, beat_cnt, m_locked, m_beats);
      end
   endtask

   task automatic test_random();
      logic [127:0] x;
      int nflip;
      for (int it = 1; it <= 400; it++) begin
         if ($urandom_range(0, 4) == 0) idle(1);
         else begin
            x = '0;
            if ($urandom_range(0, 99) < 8) begin
               if ($urandom_range(0, 3) == 0) x = rand128() | 128'h1;
               else begin
                  nflip = $urandom_range(1, 8);
                  for (int k = 0; k < nflip; k++) x[$urandom_range(0, 127)] = 1'b1;
               end
            end
            beat(x, 1);
         end
         if (it % 50 == 0) begin
            idle(4);
            n_vec++;
            if (lock !== m_locked || lock4 !== m_locked || err_flag !== m_flag || err_flag4 !== m_flag) begin
               n_err++; $display("FAIL rand_state: got lock=%b/%b flag=%b/%b expected %b %b",
                                 lock, lock4, err_flag, err_flag4, m_locked, m_flag);
            end
            n_vec++;
            if (beat_cnt !== 32'(m_beats) || err_beat_cnt !== 32'(m_ebeats) || err_bit_cnt !== 32'(m_ebits)) begin
               n_err++; $display("FAIL rand_cnt32: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                 beat_cnt, err_beat_cnt, err_bit_cnt, m_beats, m_ebeats, m_ebits);
            end
            n_vec++;
            if (beat_cnt4 !== 4'(sat(m_beats, 4)) || err_beat_cnt4 !== 4'(sat(m_ebeats, 4)) ||
                err_bit_cnt4 !== 4'(sat(m_ebits, 4))) begin
               n_err++; $display("FAIL rand_cnt4: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                 beat_cnt4, err_beat_cnt4, err_bit_cnt4,
                                 sat(m_beats, 4), sat(m_ebeats, 4), sat(m_ebits, 4));
            end
`ifdef FIRST_ERR_CAPTURE_EN
            n_vec++;
            if (first_err_xor !== m_fx || first_err_idx !== 32'(m_fidx) ||
                first_err_xor4 !== m_fx || first_err_idx4 !== 4'(sat(m_fidx, 4))) begin
               n_err++; $display("FAIL rand_capture: got %h/%0d idx4=%0d expected %h/%0d",
                                 first_err_xor, first_err_idx, first_err_idx4, m_fx, m_fidx);
            end
`endif
            if ($urandom_range(0, 3) == 0) pulse_clr();
         end
      end
   endtask

   task automatic test_saturation();
      logic [127:0] x;
      idle(4);
      pulse_clr();
      if (!m_locked) for (int i = 0; i < 16; i++) beat('0, 1);
      for (int i = 0; i < 20; i++) beat('0, 1);
      beat(128'h3FF, 1);
      beat('0, 1);
      beat(128'h3FF, 1);
      idle(4);
      n_vec++;
      if (beat_cnt4 !== 4'd15 || beat_cnt !== 32'(m_beats)) begin
         n_err++; $display("FAIL sat_beats: got %0d (32b %0d) expected 15 (%0d)", beat_cnt4, beat_cnt, m_beats);
      end
      n_vec++;
      if (err_bit_cnt4 !== 4'd15 || err_bit_cnt !== 32'(m_ebits)) begin
         n_err++; $display("FAIL sat_bits: got %0d (32b %0d) expected 15 (%0d)", err_bit_cnt4, err_bit_cnt, m_ebits);
      end
      // Bad beat reaches S3 on the same edge that samples clr.
      x = 128'h5;
      beat(x, 0);
      @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      m_beat(x, 0);
      m_clear();
      idle(4);
      n_vec++;
      if ({beat_cnt4, err_beat_cnt4, err_bit_cnt4, err_flag4} !== '0 ||
          {beat_cnt, err_beat_cnt, err_bit_cnt, err_flag} !== '0) begin
         n_err++; $display("FAIL clr_wins: got 4b %0d/%0d/%0d/%b 32b %0d/%0d/%0d/%b expected all 0",
                           beat_cnt4, err_beat_cnt4, err_bit_cnt4, err_flag4,
                           beat_cnt, err_beat_cnt, err_bit_cnt, err_flag);
      end
      n_vec++;
      if (lock !== m_locked || first_err_xor !== '0) begin
         n_err++; $display("FAIL clr_lock: got lock=%b xor=%h expected %b 0", lock, first_err_xor, m_locked);
      end
   endtask

   task automatic test_reset_midstream();
      beat(128'h1, 1);
      beat('0, 1);
      rstn = 1'b0;
      #1;
      n_vec++;
      if ({lock, err_flag, beat_cnt, err_beat_cnt, err_bit_cnt, lock4, beat_cnt4} !== '0) begin
         n_err++; $display("FAIL async_reset: got lock=%b flag=%b beats=%0d ebeats=%0d expected 0",
                           lock, err_flag, beat_cnt, err_beat_cnt);
      end
      n_vec++;
      if (first_err_xor !== '0 || first_err_idx !== '0) begin
         n_err++; $display("FAIL async_reset_capture: got xor=%h idx=%0d expected 0", first_err_xor, first_err_idx);
      end
      m_reset();
      @(posedge clk); #1;
      rstn = 1'b1;
      idle(4);
      n_vec++;
      if (lock !== m_locked || beat_cnt !== 32'(m_beats) || err_beat_cnt !== 32'(m_ebeats)) begin
         n_err++; $display("FAIL post_reset: got lock=%b beats=%0d ebeats=%0d expected %b %0d %0d",
                           lock, beat_cnt, err_beat_cnt, m_locked, m_beats, m_ebeats);
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_single_bit_err();
      test_multi_bit();
      test_loss_relock();
      test_chk_en_drop();
      test_random();
      test_saturation();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
